// File: rtl/uart_ctrl_rx_pkg.sv
// uart_ctrl_rx_pkg: shared constants for the UART receive path.
// Baud divisors are bit periods in clock cycles for a 12 MHz system clock.
package uart_ctrl_rx_pkg;

    localparam int B115200 = 104;
    localparam int B57600  = 208;
    localparam int B38400  = 313;
    localparam int B19200  = 625;
    localparam int B9600   = 1250;

    // 8N1 frame: start bit, eight data bits, stop bit
    localparam logic [3:0] FRAME_BITS = 4'd10;

endpackage : uart_ctrl_rx_pkg

// File: rtl/uart_ctrl_rx_baudgen.sv
// baudgen_rx: bit-period divisor whose strobe lands at mid-bit.
// Counter runs modulo BAUDRATE while clk_ena is high and sits at 0 otherwise,
// so the first strobe falls BAUDRATE>>1 cycles after enabling.
module baudgen_rx
    import uart_ctrl_rx_pkg::*;
#(
    parameter int BAUDRATE = B115200
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_ena,
    output logic clk_out
);

    localparam int            CW   = $clog2(BAUDRATE);
    localparam logic [CW-1:0] HALF = CW'(BAUDRATE >> 1);
    localparam logic [CW-1:0] LAST = CW'(BAUDRATE - 1);

    logic [CW-1:0] cnt_r;

    // Divisor counter: wraps at BAUDRATE-1, held at zero while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clk_ena) begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= '0;
        end
    end

    assign clk_out = clk_ena && (cnt_r == HALF);

endmodule : baudgen_rx

// File: rtl/uart_ctrl_rx.sv
// uart_ctrl_rx: 8N1 UART receiver with mid-bit sampling.
// Optional feature: define UART_RX_FRAME_ERR_EN to add the ferr output,
// which reports a stop bit sampled as 0 alongside rcv.
module uart_ctrl_rx
    import uart_ctrl_rx_pkg::*;
#(
    parameter int BAUDRATE = B115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       ferr
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        LOAD = 2'd2,
        DAV  = 2'd3
    } state_t;

    state_t     state_r;
    logic       rx_meta_r;
    logic       rx_s;
    logic [9:0] shift_r;
    logic [3:0] bitc_r;
    logic       baud_en;
    logic       clk_baud;

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s      <= rx_meta_r;
        end
    end

    assign baud_en = (state_r == RECV);

    baudgen_rx #(
        .BAUDRATE (BAUDRATE)
    ) u_baudgen (
        .clk     (clk),
        .rst     (rst),
        .clk_ena (baud_en),
        .clk_out (clk_baud)
    );

    // Receive FSM with the shift register, bit counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            shift_r <= 10'h3FF;
            bitc_r  <= 4'd0;
            data    <= 8'h00;
            rcv     <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            ferr    <= 1'b0;
`endif
        end else begin
            rcv <= 1'b0;
            case (state_r)
                IDLE: begin
                    bitc_r <= 4'd0;
                    if (!rx_s) begin
                        state_r <= RECV;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RECV: begin
                    if (bitc_r == FRAME_BITS) begin
                        state_r <= LOAD;
                    end else if ((bitc_r == 4'd1) && shift_r[9]) begin
                        // start bit read back high at mid-bit: false start
                        state_r <= IDLE;
                    end else if (clk_baud) begin
                        shift_r <= {rx_s, shift_r[9:1]};
                        bitc_r  <= bitc_r + 4'd1;
                    end else begin
                        state_r <= RECV;
                    end
                end
                LOAD: begin
                    // start bit was validated earlier; re-checked so a corrupted
                    // frame can never be presented as data
                    if (!shift_r[0]) begin
                        data    <= shift_r[8:1];
`ifdef UART_RX_FRAME_ERR_EN
                        ferr    <= ~shift_r[9];
`endif
                        rcv     <= 1'b1;
                        state_r <= DAV;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DAV: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule : uart_ctrl_rx

// File: tb/tb_uart_ctrl_rx.sv
// tb_uart_ctrl_rx: randomized self-checking bench for uart_ctrl_rx.
// A serialiser drives rx; each delivered frame is queued as the byte the
// receiver must present, and a per-cycle monitor checks data/rcv(/ferr).
module tb_uart_ctrl_rx;

    localparam int BAUD = 104;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       rcv;
`ifdef UART_RX_FRAME_ERR_EN
    logic       ferr;
`endif

    int checks    = 0;
    int errors    = 0;
    int rcv_count = 0;

    logic [8:0] exp_q[$];     // {expected ferr, expected byte}
    logic [7:0] model_data = 8'h00;
    logic       model_ferr = 1'b0;
    logic       prev_rcv   = 1'b0;

    uart_ctrl_rx #(
        .BAUDRATE (BAUD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .data (data),
        .rcv  (rcv)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .ferr (ferr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle monitor: every rcv consumes one queued frame; data/ferr must
    // always equal the last delivered frame
    always @(negedge clk) begin
        if (rst) begin
            model_data = 8'h00;
            model_ferr = 1'b0;
            prev_rcv   = 1'b0;
        end else begin
            if (rcv) begin
                rcv_count++;
                check("rcv_single_cycle", {31'd0, prev_rcv}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rcv: got data 0x%0h expected no pulse at %0t", data, $time);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    model_data = e[7:0];
                    model_ferr = e[8];
                end
            end
            check("data", {24'd0, data}, {24'd0, model_data});
`ifdef UART_RX_FRAME_ERR_EN
            check("ferr", {31'd0, ferr}, {31'd0, model_ferr});
`endif
            prev_rcv = rcv;
        end
    end

    // Bit-accurate 8N1 serialiser; period in clock cycles per bit
    task automatic send_frame(input logic [7:0] b, input int period, input logic stop, input bit push);
        if (push) begin
`ifdef UART_RX_FRAME_ERR_EN
            exp_q.push_back({~stop, b});
`else
            exp_q.push_back({1'b0, b});
`endif
        end
        rx = 1'b0;
        repeat (period) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (period) @(negedge clk);
        end
        rx = stop;
        repeat (period) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BAUD) @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_rcv", {31'd0, rcv}, 32'd0);
        rst = 1'b0;
        idle_bits(1);

        // two frames separated by three idle bit-times
        send_frame(8'h55, BAUD, 1'b1, 1'b1);
        check("data_after_55", {24'd0, data}, 32'h55);
        idle_bits(3);
        send_frame(8'hA3, BAUD, 1'b1, 1'b1);
        idle_bits(3);
        wait_drain();
        check("data_after_A3", {24'd0, data}, 32'hA3);
        check("rcv_count_2", rcv_count, 32'd2);

        // short low glitch must be rejected at the first mid-bit sample
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        idle_bits(3);
        check("glitch_no_rcv", rcv_count, 32'd2);
        check("glitch_data_held", {24'd0, data}, 32'hA3);

        // 16 random bytes back to back, no idle gap
        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom_range(0, 255));
            send_frame(rb, BAUD, 1'b1, 1'b1);
        end
        idle_bits(3);
        wait_drain();
        check("rcv_count_18", rcv_count, 32'd18);

`ifdef UART_RX_FRAME_ERR_EN
        // bad stop bit: byte still delivered with ferr set, cleared by next good frame
        send_frame(8'h3C, BAUD, 1'b0, 1'b1);
        idle_bits(3);
        wait_drain();
        check("ferr_data_3C", {24'd0, data}, 32'h3C);
        check("ferr_set", {31'd0, ferr}, 32'd1);
        send_frame(8'h5A, BAUD, 1'b1, 1'b1);
        idle_bits(3);
        wait_drain();
        check("ferr_cleared", {31'd0, ferr}, 32'd0);
`endif

        // reset in the middle of d4; remaining bits of 0xF0 are all high
        rcv_count = 0;
        fork
            send_frame(8'hF0, BAUD, 1'b1, 1'b0);
            begin
                repeat (BAUD * 5 + BAUD / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        idle_bits(3);
        check("abort_no_rcv", rcv_count, 32'd0);
        check("abort_data_cleared", {24'd0, data}, 32'h00);
        send_frame(8'h81, BAUD, 1'b1, 1'b1);
        idle_bits(3);
        wait_drain();
        check("after_abort_81", {24'd0, data}, 32'h81);
        check("after_abort_count", rcv_count, 32'd1);

        // transmitter 4% slow, then 4% fast
        send_frame(8'hF0, (BAUD * 104) / 100, 1'b1, 1'b1);
        idle_bits(3);
        wait_drain();
        check("skew_slow_F0", {24'd0, data}, 32'hF0);
        send_frame(8'h0F, BAUD, 1'b1, 1'b1);
        idle_bits(3);
        send_frame(8'hF0, (BAUD * 96) / 100, 1'b1, 1'b1);
        idle_bits(3);
        wait_drain();
        check("skew_fast_F0", {24'd0, data}, 32'hF0);
        check("skew_count", rcv_count, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_ctrl_rx
